// File: rtl/dac_spi_mixer.sv
// dac_spi_mixer
// Mixes two unsigned synth channel samples into one 12-bit DAC word at a
// fixed sample rate. Each word goes to an MCP4921-style SPI DAC as a 16-bit
// frame, MSB first, with a 4-bit config header in front of it.
//
// Ports:
//   clk            system clock
//   rst            asynchronous reset, active low
//   ch0, ch1       channel samples, N bits unsigned
//   mute           forces the DAC data field to zero when sampled at latch time
//   dac_cs_n       SPI chip select, active low
//   dac_sclk       SPI clock, idles low; the DAC samples on the rising edge
//   dac_mosi       SPI data, MSB first
//   busy           high from chip-select fall through the inter-frame gap
//   sample_strobe  one-cycle pulse on the cycle after a sample is latched
//   overrun        sticky flag, set when a sample tick arrives mid-frame
module dac_spi_mixer #(
    parameter int         N          = 11,
    parameter int         SCLK_DIV   = 2,
    parameter int         SAMPLE_DIV = 500,
    parameter logic [3:0] CONFIG     = 4'b0111
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] ch0,
    input  logic [N-1:0] ch1,
    input  logic         mute,
    output logic         dac_cs_n,
    output logic         dac_sclk,
    output logic         dac_mosi,
    output logic         busy,
    output logic         sample_strobe,
    output logic         overrun
);

    // Counter widths are clamped to at least one bit so that a divider of 1
    // still elaborates.
    localparam int HW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(SCLK_DIV - 1);
    localparam logic [TW-1:0] T_LAST = TW'(SAMPLE_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOW  = 3'd1,
        ST_HIGH = 3'd2,
        ST_TAIL = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    state_t          state_r;
    logic [TW-1:0]   timer_r;
    logic [HW-1:0]   hcnt_r;
    logic [3:0]      bit_r;
    logic [15:0]     frame_r;

    logic            tick_s;
    logic            half_done_s;
    logic [N:0]      sum_s;
    logic [15:0]     word_s;

    // Sample tick, half-period completion and the next frame word.
    // The sum of two N-bit values fits in N+1 bits, so it needs no saturation.
    always_comb begin
        tick_s      = (timer_r == T_LAST);
        half_done_s = (hcnt_r == H_LAST);
        sum_s       = {1'b0, ch0} + {1'b0, ch1};
        if (mute) begin
            word_s = {CONFIG, {(N + 1){1'b0}}};
        end else begin
            word_s = {CONFIG, sum_s};
        end
    end

    // Sample timer, overrun flag and SPI frame sequencer with registered pins.
    // The timer free-runs even while a frame is in flight. A tick that arrives
    // in any state other than IDLE, including the last GAP cycle, is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            timer_r       <= '0;
            hcnt_r        <= '0;
            bit_r         <= 4'd15;
            frame_r       <= 16'd0;
            dac_cs_n      <= 1'b1;
            dac_sclk      <= 1'b0;
            dac_mosi      <= 1'b0;
            busy          <= 1'b0;
            sample_strobe <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            timer_r       <= tick_s ? '0 : timer_r + TW'(1);
            if (tick_s && (state_r != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (tick_s) begin
                        frame_r       <= word_s;
                        bit_r         <= 4'd15;
                        hcnt_r        <= '0;
                        dac_mosi      <= word_s[15];
                        dac_cs_n      <= 1'b0;
                        busy          <= 1'b1;
                        sample_strobe <= 1'b1;
                        state_r       <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (half_done_s) begin
                        hcnt_r   <= '0;
                        dac_sclk <= 1'b1;
                        state_r  <= ST_HIGH;
                    end else begin
                        hcnt_r <= hcnt_r + HW'(1);
                    end
                end
                ST_HIGH: begin
                    // mosi only moves on the falling sclk edge so it is stable
                    // across the DAC's rising-edge sample.
                    if (half_done_s) begin
                        hcnt_r   <= '0;
                        dac_sclk <= 1'b0;
                        if (bit_r == 4'd0) begin
                            dac_mosi <= 1'b0;
                            state_r  <= ST_TAIL;
                        end else begin
                            bit_r    <= bit_r - 4'd1;
                            dac_mosi <= frame_r[bit_r - 4'd1];
                            state_r  <= ST_LOW;
                        end
                    end else begin
                        hcnt_r <= hcnt_r + HW'(1);
                    end
                end
                ST_TAIL: begin
                    if (half_done_s) begin
                        hcnt_r   <= '0;
                        dac_cs_n <= 1'b1;
                        state_r  <= ST_GAP;
                    end else begin
                        hcnt_r <= hcnt_r + HW'(1);
                    end
                end
                ST_GAP: begin
                    if (half_done_s) begin
                        hcnt_r  <= '0;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        hcnt_r <= hcnt_r + HW'(1);
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    hcnt_r   <= '0;
                    dac_cs_n <= 1'b1;
                    dac_sclk <= 1'b0;
                    dac_mosi <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_mixer.sv
// tb_dac_spi_mixer
// Three instances of dac_spi_mixer with different dividers:
//   0: SAMPLE_DIV=500, SCLK_DIV=2  (table vectors, mid-frame input change, mid-frame reset)
//   1: SAMPLE_DIV=40,  SCLK_DIV=2  (overrun, every other tick dropped)
//   2: SAMPLE_DIV=500, SCLK_DIV=1  (fastest sclk)
// Each instance has a timing model that follows the expected latch cycles
// and predicts the pins on every cycle. A queue holds the frame words
// pushed when stimulus is applied, and each completed frame is compared
// against the next word in that queue.
`timescale 1ns/1ps
module tb_dac_spi_mixer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v    [3];
    logic [10:0] ch0_v    [3];
    logic [10:0] ch1_v    [3];
    logic        mute_v   [3];
    logic        cs_n_v   [3];
    logic        sclk_v   [3];
    logic        mosi_v   [3];
    logic        busy_v   [3];
    logic        strobe_v [3];
    logic        ovr_v    [3];

    logic [15:0] exp_q [3][$];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [10:0] c0;
        logic [10:0] c1;
        logic        m;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int SD = (g == 1) ? 40 : 500;
        localparam int H  = (g == 2) ? 1 : 2;

        logic rst_l;
        assign rst_l = rst_v[g];

        dac_spi_mixer #(
            .N(11), .SCLK_DIV(H), .SAMPLE_DIV(SD), .CONFIG(4'b0111)
        ) u_dut (
            .clk(clk), .rst(rst_l),
            .ch0(ch0_v[g]), .ch1(ch1_v[g]), .mute(mute_v[g]),
            .dac_cs_n(cs_n_v[g]), .dac_sclk(sclk_v[g]), .dac_mosi(mosi_v[g]),
            .busy(busy_v[g]), .sample_strobe(strobe_v[g]), .overrun(ovr_v[g])
        );

        // pe = clock edges since reset release, equal to the expected sample timer
        int pe = 0;
        always @(posedge clk or negedge rst_l) begin
            if (!rst_l) pe <= 0;
            else        pe <= pe + 1;
        end

        int          fs;        // cycle in which the current frame's strobe is expected
        logic        ovr_m;
        logic        prev_sclk;
        logic        prev_cs;
        logic [15:0] cap;
        int          edges;

        always @(negedge clk) begin : mon
            int          off;
            logic [15:0] front;
            logic        exp_mosi;
            logic [5:0]  exp_bus;
            logic [5:0]  act_bus;
            if (!rst_l) begin
                fs        = -1;
                ovr_m     = 1'b0;
                prev_sclk = 1'b0;
                prev_cs   = 1'b1;
                edges     = 0;
                cap       = 16'd0;
            end
            off = (fs >= 0 && pe >= fs) ? (pe - fs) : 34 * H;
            exp_mosi = 1'b0;
            if (off < 32 * H && exp_q[g].size() > 0) begin
                front    = exp_q[g][0];
                exp_mosi = front[15 - off / (2 * H)];
            end
            exp_bus = {(pe == fs), (off < 34 * H), !(off < 33 * H),
                       (off < 32 * H) && (((off / H) % 2) == 1), exp_mosi, ovr_m};
            act_bus = {strobe_v[g], busy_v[g], cs_n_v[g], sclk_v[g], mosi_v[g], ovr_v[g]};
            chk($sformatf("pins{strb,busy,cs_n,sclk,mosi,ovr} inst%0d cyc%0d", g, pe),
                int'(act_bus), int'(exp_bus));
            if (rst_l) begin
                if (!cs_n_v[g] && prev_cs) begin
                    edges = 0;
                    cap   = 16'd0;
                end
                if (sclk_v[g] && !prev_sclk && !cs_n_v[g]) begin
                    cap   = {cap[14:0], mosi_v[g]};
                    edges = edges + 1;
                end
                if (cs_n_v[g] && !prev_cs) begin
                    if (exp_q[g].size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL frame inst%0d: got 0x%0h, expected no frame", g, cap);
                    end else begin
                        chk($sformatf("frame inst%0d", g), int'(cap), int'(exp_q[g].pop_front()));
                        chk($sformatf("sclk_rises inst%0d", g), edges, 16);
                    end
                end
                // latch model: a tick latches only if the previous frame's gap is over
                if ((pe % SD) == (SD - 1)) begin
                    if (fs < 0 || pe >= fs + 34 * H) fs = pe + 1;
                    else ovr_m = 1'b1;
                end
                prev_sclk = sclk_v[g];
                prev_cs   = cs_n_v[g];
            end
        end
    end

    task automatic drive(input int g, input logic [10:0] a, input logic [10:0] b, input logic m);
        ch0_v[g]  = a;
        ch1_v[g]  = b;
        mute_v[g] = m;
    endtask

    task automatic release_rst(input int g);
        @(negedge clk);
        #2 rst_v[g] = 1'b1;
    endtask

    task automatic wait_strobe(input int g, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!strobe_v[g] && k < budget);
        if (!strobe_v[g]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL strobe_timeout inst%0d: none within %0d cycles", g, budget);
        end
    endtask

    task automatic wait_idle(input int g, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy_v[g] && k < budget);
        if (busy_v[g]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL busy_timeout inst%0d: still busy after %0d cycles", g, budget);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b1;
            drive(i, 11'h000, 11'h000, 1'b0);
        end
        #1;
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;

        vecs[0] = '{11'h400, 11'h3FF, 1'b0, 16'h77FF};
        vecs[1] = '{11'h7FF, 11'h7FF, 1'b0, 16'h7FFE};
        vecs[2] = '{11'h000, 11'h000, 1'b0, 16'h7000};
        vecs[3] = '{11'h123, 11'h0AB, 1'b1, 16'h7000};
        vecs[4] = '{11'h001, 11'h7FF, 1'b0, 16'h7800};
        vecs[5] = '{11'h555, 11'h0AA, 1'b0, 16'h75FF};

        repeat (3) @(negedge clk);
        chk("reset cs_n", int'(cs_n_v[0]), 1);
        chk("reset busy", int'(busy_v[0]), 0);
        chk("reset overrun", int'(ovr_v[0]), 0);

        // instance 0: table vectors; inputs change while the previous frame is in flight
        release_rst(0);
        for (int i = 0; i < 6; i++) begin
            drive(0, vecs[i].c0, vecs[i].c1, vecs[i].m);
            exp_q[0].push_back(vecs[i].exp);
            wait_strobe(0, 520);
        end

        // ch0 changes at frame cycle 10: current frame keeps the old sum
        drive(0, 11'h100, 11'h000, 1'b0);
        exp_q[0].push_back(16'h7100);
        wait_strobe(0, 520);
        repeat (9) @(negedge clk);
        drive(0, 11'h700, 11'h000, 1'b0);
        exp_q[0].push_back(16'h7700);
        wait_strobe(0, 520);

        // reset during bit 8 aborts the frame; next frame waits for a fresh tick
        drive(0, 11'h2AA, 11'h155, 1'b0);
        exp_q[0].push_back(16'h73FF);
        wait_strobe(0, 520);
        repeat (29) @(negedge clk);
        chk("mid-frame cs_n", int'(cs_n_v[0]), 0);
        #2 rst_v[0] = 1'b0;
        #1;
        chk("async rst cs_n", int'(cs_n_v[0]), 1);
        chk("async rst sclk", int'(sclk_v[0]), 0);
        chk("async rst mosi", int'(mosi_v[0]), 0);
        chk("async rst busy", int'(busy_v[0]), 0);
        chk("async rst overrun", int'(ovr_v[0]), 0);
        exp_q[0].delete();
        repeat (3) @(negedge clk);
        #2 rst_v[0] = 1'b1;
        drive(0, 11'h100, 11'h023, 1'b0);
        exp_q[0].push_back(16'h7123);
        wait_strobe(0, 520);
        wait_idle(0, 100);
        #2 rst_v[0] = 1'b0;

        // instance 1: ticks every 40 cycles against a 68-cycle frame
        release_rst(1);
        drive(1, 11'h0F0, 11'h00F, 1'b0);
        repeat (3) exp_q[1].push_back(16'h70FF);
        wait_strobe(1, 60);
        chk("overrun after first tick", int'(ovr_v[1]), 0);
        wait_strobe(1, 100);
        chk("overrun after dropped tick", int'(ovr_v[1]), 1);
        wait_strobe(1, 100);
        wait_idle(1, 100);
        #2 rst_v[1] = 1'b0;

        // instance 2: SCLK_DIV=1
        release_rst(2);
        drive(2, 11'h400, 11'h3FF, 1'b0);
        exp_q[2].push_back(16'h77FF);
        wait_strobe(2, 520);
        drive(2, 11'h7FF, 11'h001, 1'b0);
        exp_q[2].push_back(16'h7800);
        wait_strobe(2, 520);
        wait_idle(2, 60);
        #2 rst_v[2] = 1'b0;

        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("frames left inst%0d", i), exp_q[i].size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
